// File: rtl/mat_result_streamer_if.sv
// Handshake bundle between the matrix producer, the element streamer and the
// narrow element consumer. The master side is the upstream/downstream
// environment; the slave side is the streamer itself.
interface mat_result_streamer_if #(
    parameter int unsigned Bit = 3,
    parameter int unsigned N   = 2,
    parameter int unsigned P   = 2
);
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;

    logic                 load;
    logic                 load_ready;
    logic [Bit*N*P-1:0]   matriz_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [Bit-1:0]       out_data;
    logic [RW-1:0]        out_row;
    logic [CW-1:0]        out_col;
    logic                 out_last;
    logic                 busy;

    modport master (
        output load, matriz_in, out_ready,
        input  load_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );

    modport slave (
        input  load, matriz_in, out_ready,
        output load_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );
endinterface

// File: rtl/mat_result_streamer.sv
// Streams a packed N x P result matrix out one element per handshake in
// row-major order. An active buffer drains while a pending buffer holds the
// next matrix, so back-to-back matrices stream without bubbles.
module mat_result_streamer #(
    parameter int unsigned Bit = 3,
    parameter int unsigned N   = 2,
    parameter int unsigned P   = 2
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 clk_enable,
    mat_result_streamer_if.slave bus
);
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned W  = Bit * N * P;

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e          state_q, state_d;
    logic            pend_full_q, pend_full_d;
    logic [W-1:0]    act_q, act_d;
    logic [W-1:0]    pend_q, pend_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   c_q, c_d;

    logic            accept;
    logic            fire;
    logic            last;
    logic            load_ready;
    logic            out_valid;

    // Unpack the active matrix so the element select is a plain 2-D index.
    logic [Bit-1:0]  elems [N][P];
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < P; j++) begin : g_col
            assign elems[i][j] = act_q[(i*P+j)*Bit +: Bit];
        end
    end

    // Handshake qualifiers and element outputs, all derived from registers.
    always_comb begin
        load_ready = clk_enable & ~pend_full_q;
        out_valid  = clk_enable & (state_q == StStream);
        last       = (r_q == RW'(N-1)) && (c_q == CW'(P-1));
        accept     = bus.load & load_ready;
        fire       = out_valid & bus.out_ready;

        bus.load_ready = load_ready;
        bus.out_valid  = out_valid;
        bus.out_data   = elems[r_q][c_q];
        bus.out_row    = r_q;
        bus.out_col    = c_q;
        bus.out_last   = last;
        bus.busy       = (state_q == StStream) | pend_full_q;
    end

    // Next-state: index advance on fire, buffer hand-over at matrix end.
    always_comb begin
        state_d     = state_q;
        pend_full_d = pend_full_q;
        act_d       = act_q;
        pend_d      = pend_q;
        r_d         = r_q;
        c_d         = c_q;

        if (fire) begin
            if (last) begin
                r_d = '0;
                c_d = '0;
                if (pend_full_q) begin
                    act_d       = pend_q;
                    pend_full_d = 1'b0;
                end else if (accept) begin
                    // New matrix bypasses the pending slot entirely.
                    act_d = bus.matriz_in;
                end else begin
                    state_d = StIdle;
                end
            end else if (c_q == CW'(P-1)) begin
                c_d = '0;
                r_d = r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end

        if (accept && !(fire && last)) begin
            if (state_q == StIdle) begin
                act_d   = bus.matriz_in;
                state_d = StStream;
                r_d     = '0;
                c_d     = '0;
            end else begin
                pend_d      = bus.matriz_in;
                pend_full_d = 1'b1;
            end
        end
    end

    // State registers; with clk_enable low no accept/fire occurs, so all hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_full_q <= 1'b0;
            act_q       <= '0;
            pend_q      <= '0;
            r_q         <= '0;
            c_q         <= '0;
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            r_q         <= r_d;
            c_q         <= c_d;
        end
    end
endmodule

// File: doc/mat_result_streamer.md
# mat_result_streamer

Receives a packed result matrix (N rows × P columns, Bit bits per element) from the matrix-multiply datapath in one transfer. It streams the elements out one per handshake in row-major order, tagging each with its row/column index and an end-of-matrix flag. A pending slot accepts the next matrix while the current one drains, so back-to-back matrices stream without bubbles. It sits between the multiplier's `matriz_resultado` bus and any narrow element-wide consumer.

## Interface
- `Bit`, 3, element width in bits
- `N`, 2, rows of result matrix
- `P`, 2, columns of result matrix
- Derived: `RW = max(1,$clog2(N))`, `CW = max(1,$clog2(P))`

- `clk`  in  1  clock; everything on rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `clk_enable`  in  1  global advance enable; low freezes all state
- `load`  in  1  upstream offers `matriz_in`
- `load_ready`  out  1  pending slot free and `clk_enable`=1
- `matriz_in`  in  Bit*N*P  packed matrix; element (i,j) at bits `[(i*P+j)*Bit +: Bit]`
- `out_valid`  out  1  element available and `clk_enable`=1
- `out_ready`  in  1  downstream accepts element
- `out_data`  out  Bit  current element
- `out_row`  out  RW  row index i of `out_data`
- `out_col`  out  CW  column index j of `out_data`
- `out_last`  out  1  high with element (N-1,P-1)
- `busy`  out  1  active or pending slot occupied

## Operation
- State:
  - active buffer `act` + flag `act_full`
  - pending buffer `pend` + flag `pend_full`
  - row counter `r` and column counter `c`
- `accept = load & load_ready`; `fire = out_valid & out_ready`. Both require `clk_enable`=1 by construction.
- `load_ready = clk_enable & !pend_full`.
- `out_valid = clk_enable & act_full`.
- Outputs are combinational from registers:
  - `out_data = act[(r*P+c)*Bit +: Bit]`
  - `out_row = r`, `out_col = c`
  - `out_last = (r==N-1)&(c==P-1)`
  - `busy = act_full|pend_full`
- Two effective states:
  - IDLE (`act_full`=0)
  - STREAM (`act_full`=1); `pend_full` is an independent sub-flag
- `fire` and not last: c←c+1; at c==P-1, c←0 and r←r+1.
- `fire` and last: r←0, c←0, then:
  - if `pend_full`: act←pend, pend_full←0
  - else if `accept`: act←matriz_in
  - else: act_full←0
- `accept` without (`fire` & last):
  - act_full=0: act←matriz_in, act_full←1, r,c←0
  - act_full=1: pend←matriz_in, pend_full←1
- Simultaneous `accept` with `fire` & last and `pend_full`=0: the matrix goes straight to `act`. The pending slot stays empty.
- `clk_enable`=0: no register changes. `load`/`out_ready` are ignored. `load_ready`/`out_valid` read 0, while data and index outputs hold their values.
- Input sampled only on the `accept` cycle; `matriz_in` may change afterwards.
- No arithmetic on element values; indices never exceed N-1 / P-1.

## Timing
- Reset: `act_full`=`pend_full`=0, r=c=0, `act`=`pend`=0.
  - Therefore `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=(N==1&&P==1), `busy`=0.
  - `load_ready`=`clk_enable`.
- Reset mid-stream discards both buffers. The stream restarts only on the next `accept`.
- Latency: `accept` in cycle t from IDLE gives `out_valid`=1 with element (0,0) in t+1.
- Throughput: one element per cycle while `out_ready`=1. With `out_ready` tied high and upstream offering continuously, there are no gaps between matrices.
- `out_ready` low: outputs hold the same element and indices indefinitely.
- Full: both slots occupied means `load_ready`=0. It returns to 1 the cycle after the last-element `fire` moves `pend` into `act`.

## Test plan
All scenarios use Bit=3, N=P=2, `clk_enable`=1 unless stated.

1. **Reset values.** Assert `rst` for 2 cycles -> `out_valid`=0, `busy`=0, `load_ready`=1, `out_data`=0, `out_row`=0, `out_col`=0.
2. **Single matrix.** Load `matriz_in`=12'h8D1 with `out_ready`=1 -> next 4 cycles give `out_data`=1,2,3,4 with (row,col)=(0,0),(0,1),(1,0),(1,1). `out_last` is high only on 4, then `out_valid`=0.
3. **Back-to-back.** Load 12'h8D1, then 12'h177 the following cycle -> 8 consecutive valid cycles: 1,2,3,4,7,6,5,0. `load_ready` drops while pending is full.
4. **Backpressure.** Load 12'h8D1 and hold `out_ready`=0 for 5 cycles -> element 1 at (0,0) is held throughout. Release -> 2,3,4 follow one per cycle.
5. **Simultaneous last fire and load.** Pending empty, load 12'h177 on the same cycle element 4 fires -> next cycle shows 7 at (0,0) with no bubble; `pend_full` stays 0.
6. **Freeze and reset.**
   - `clk_enable`=0 mid-stream for 3 cycles -> `out_valid`=0, indices frozen; resumes at the same element.
   - Then `rst` at element (1,0) -> `out_valid`=0 next cycle, `busy`=0.
